// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard unit. It keeps a private shadow of the producers that
// occupy the E, M and W stages. For every source operand presented at decode
// it picks the forwarding path, or it raises a decode stall when the youngest
// matching producer has not yet produced its result.
//
// Optional feature: define HAZ_MDU_EN to track a multi-cycle multiply/divide
// unit with a busy counter. Without the macro the MDU inputs are ignored and
// mdu_busy is tied low.
//
// Handshake: the decode instruction is accepted on a rising edge when
// issue_valid=1, stall_d=0 and stall_ext=0. stall_d is purely combinational
// on the current shadow state and the current inputs. When stall_d or
// stall_ext is high, the instruction must be held and presented again.
//
// Ports:
//   clk              clock; all state changes on the rising edge
//   resetn           asynchronous active-low reset
//   issue_valid      a decode instruction is presented
//   issue_we         the instruction writes a register
//   issue_dst        destination register index
//   issue_rdy        stage at whose end the result can be forwarded
//                    (0=E, 1=M, 2=W; 3 behaves as 2)
//   src_idx          NUM_SRC packed source indices; port k at [k*REG_W +: REG_W]
//   issue_mdu_start  the instruction starts an MDU operation
//   issue_mdu_read   the instruction reads HI/LO
//   stall_ext        external pipeline freeze
//   flush            kill every in-flight E/M/W producer
//   stall_d          decode must hold; the instruction is not accepted
//   fwd_sel          per-source select, 2 bits each
//                    (0=regfile, 1=E, 2=M, 3=W)
//   mdu_busy         the MDU counter is nonzero
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 5,
    parameter int MDU_LAT = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       issue_valid,
    input  logic                       issue_we,
    input  logic [REG_W-1:0]           issue_dst,
    input  logic [1:0]                 issue_rdy,
    input  logic [NUM_SRC*REG_W-1:0]   src_idx,
    input  logic                       issue_mdu_start,
    input  logic                       issue_mdu_read,
    input  logic                       stall_ext,
    input  logic                       flush,
    output logic                       stall_d,
    output logic [NUM_SRC*2-1:0]       fwd_sel,
    output logic                       mdu_busy
);

    localparam int NSTG  = 3;   // stage positions: 0=E, 1=M, 2=W
    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] dst;
        logic [1:0]       rdy;   // stored already clamped to 0..2
    } entry_t;

    entry_t stg_q [NSTG];
    entry_t stg_d [NSTG];

    logic [NUM_SRC-1:0] src_hazard;
    logic               mdu_hazard;
    logic               accept;
    logic [1:0]         rdy_clamped;

    // ------------------------------------------------------------------
    // Operand lookup. The scan runs youngest first, so a younger write to
    // the same register hides an older one. A match counts as available
    // once the producer has reached or passed its ready stage. W is always
    // available because the clamped rdy never exceeds 2.
    // ------------------------------------------------------------------
    always_comb begin : lookup
        logic             found;
        logic [REG_W-1:0] src;
        fwd_sel    = '0;
        src_hazard = '0;
        found      = 1'b0;
        src        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src   = src_idx[k*REG_W +: REG_W];
            found = 1'b0;
            for (int p = 0; p < NSTG; p++) begin
                if (!found && stg_q[p].v && (stg_q[p].dst == src) && (src != '0)) begin
                    found = 1'b1;
                    if (2'(p) >= stg_q[p].rdy) begin
                        fwd_sel[k*2 +: 2] = 2'(p + 1);
                    end else begin
                        src_hazard[k] = 1'b1;
                    end
                end
            end
        end
    end

    assign stall_d     = issue_valid & ((|src_hazard) | mdu_hazard);
    assign accept      = issue_valid & ~stall_d & ~stall_ext;
    assign rdy_clamped = (issue_rdy == 2'd3) ? 2'd2 : issue_rdy;

    // ------------------------------------------------------------------
    // Shadow advance. A flush wins over a freeze. An unaccepted cycle
    // pushes a bubble into E.
    // ------------------------------------------------------------------
    always_comb begin : shadow_next
        for (int p = 0; p < NSTG; p++) begin
            stg_d[p] = stg_q[p];
        end
        if (flush) begin
            for (int p = 0; p < NSTG; p++) begin
                stg_d[p].v = 1'b0;
            end
        end else if (!stall_ext) begin
            stg_d[STG_W] = stg_q[STG_M];
            stg_d[STG_M] = stg_q[STG_E];
            if (accept) begin
                stg_d[STG_E].v   = issue_we & (issue_dst != '0);
                stg_d[STG_E].dst = issue_dst;
                stg_d[STG_E].rdy = rdy_clamped;
            end else begin
                stg_d[STG_E] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < NSTG; p++) begin
                stg_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NSTG; p++) begin
                stg_q[p] <= stg_d[p];
            end
        end
    end

`ifdef HAZ_MDU_EN
    // ------------------------------------------------------------------
    // MDU busy counter. Once an operation starts it always runs to
    // completion. Neither a freeze nor a flush affects the countdown.
    // A start is only accepted while the counter is zero, because a busy
    // MDU stalls any new start.
    // ------------------------------------------------------------------
    localparam int CNT_W = $clog2(MDU_LAT + 1);

    logic [CNT_W-1:0] mdu_cnt_q;
    logic [CNT_W-1:0] mdu_cnt_d;

    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (accept && issue_mdu_start) begin
            mdu_cnt_d = CNT_W'(MDU_LAT);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdu_cnt_q <= '0;
        end else begin
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

    assign mdu_busy   = (mdu_cnt_q != '0);
    assign mdu_hazard = mdu_busy & (issue_mdu_start | issue_mdu_read);
`else
    // No MDU tracking: the MDU inputs are deliberately left unused.
    logic [31:0] unused_mdu;
    assign unused_mdu = {30'(MDU_LAT), issue_mdu_start, issue_mdu_read};
    assign mdu_busy   = 1'b0;
    assign mdu_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Exercises hazard_scoreboard with directed scenarios followed by random
// traffic. Expected outputs come from a reference model held inside the
// bench; a monitor process compares the DUT against them.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    localparam int NUM_SRC = 2;
    localparam int REG_W   = 5;
    localparam int MDU_LAT = 4;
    localparam int EW      = 2 + 2*NUM_SRC;   // {mdu_busy, stall_d, fwd_sel}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic                     issue_valid = 1'b0;
    logic                     issue_we = 1'b0;
    logic [REG_W-1:0]         issue_dst = '0;
    logic [1:0]               issue_rdy = '0;
    logic [NUM_SRC*REG_W-1:0] src_idx = '0;
    logic                     issue_mdu_start = 1'b0;
    logic                     issue_mdu_read = 1'b0;
    logic                     stall_ext = 1'b0;
    logic                     flush = 1'b0;
    logic                     stall_d;
    logic [NUM_SRC*2-1:0]     fwd_sel;
    logic                     mdu_busy;

    hazard_scoreboard #(.NUM_SRC(NUM_SRC), .REG_W(REG_W), .MDU_LAT(MDU_LAT)) dut (
        .clk(clk), .resetn(resetn),
        .issue_valid(issue_valid), .issue_we(issue_we),
        .issue_dst(issue_dst), .issue_rdy(issue_rdy),
        .src_idx(src_idx),
        .issue_mdu_start(issue_mdu_start), .issue_mdu_read(issue_mdu_read),
        .stall_ext(stall_ext), .flush(flush),
        .stall_d(stall_d), .fwd_sel(fwd_sel), .mdu_busy(mdu_busy)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Each producer is described by its stage (0=E, 1=M, 2=W), whether it
    // writes a register, its destination and the stage at which its result
    // becomes ready.
    bit               m_v [3];
    logic [REG_W-1:0] m_d [3];
    int               m_r [3];
    int               m_cnt;

    function automatic void model_reset();
        for (int p = 0; p < 3; p++) begin
            m_v[p] = 1'b0; m_d[p] = '0; m_r[p] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic logic [EW-1:0] model_out();
        logic [2*NUM_SRC-1:0] sel;
        logic [REG_W-1:0]     s;
        bit haz, busy, mh, st;
        int ready_at;
        sel = '0;
        haz = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            s = src_idx[k*REG_W +: REG_W];
            if (s != 0) begin
                for (int p = 0; p < 3; p++) begin
                    if (m_v[p] && m_d[p] == s) begin
                        ready_at = (m_r[p] > 2) ? 2 : m_r[p];
                        if (p >= ready_at) sel[k*2 +: 2] = 2'(p + 1);
                        else haz = 1'b1;
                        break;
                    end
                end
            end
        end
`ifdef HAZ_MDU_EN
        busy = (m_cnt != 0);
`else
        busy = 1'b0;
`endif
        mh = busy && (issue_mdu_start || issue_mdu_read);
        st = issue_valid && (haz || mh);
        return {busy, st, sel};
    endfunction

    function automatic void model_step();
        logic [EW-1:0] o;
        bit acc;
        o   = model_out();
        acc = issue_valid && !o[EW-2] && !stall_ext;
`ifdef HAZ_MDU_EN
        if (acc && issue_mdu_start) m_cnt = MDU_LAT;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
`endif
        if (flush) begin
            for (int p = 0; p < 3; p++) m_v[p] = 1'b0;
        end else if (!stall_ext) begin
            for (int p = 2; p > 0; p--) begin
                m_v[p] = m_v[p-1]; m_d[p] = m_d[p-1]; m_r[p] = m_r[p-1];
            end
            m_v[0] = acc && issue_we && (issue_dst != 0);
            m_d[0] = issue_dst;
            m_r[0] = int'(issue_rdy);
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Called at posedge+1 with the inputs already applied.
    task automatic cycle(string tag);
        exp_q.push_back(model_out());
        tag_q.push_back(tag);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_in();
        issue_valid = 0; issue_we = 0; issue_dst = '0; issue_rdy = '0;
        src_idx = '0; issue_mdu_start = 0; issue_mdu_read = 0;
        stall_ext = 0; flush = 0;
    endtask

    task automatic write(input logic [REG_W-1:0] dst, input logic [1:0] rdy);
        clear_in();
        issue_valid = 1; issue_we = 1; issue_dst = dst; issue_rdy = rdy;
    endtask

    task automatic set_src(input logic [REG_W-1:0] s0, input logic [REG_W-1:0] s1);
        src_idx = {s1, s0};
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'({mdu_busy, stall_d, fwd_sel}), 32'(e));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        clear_in();
        set_src(5'd8, 5'd9);
        issue_valid = 1;
        #12;
        check("reset_stall", 32'(stall_d), 32'd0);
        check("reset_fwd", 32'(fwd_sel), 32'd0);
        check("reset_busy", 32'(mdu_busy), 32'd0);
        @(posedge clk); #1;
        resetn = 1;
        clear_in();

        // Forwarding from every stage
        write(5'd8, 2'd0);           cycle("alu_issue");
        clear_in(); set_src(5'd8, 5'd0);
        cycle("fwd_e"); cycle("fwd_m"); cycle("fwd_w"); cycle("fwd_gone");

        // Load-use stall
        write(5'd9, 2'd1);           cycle("load_issue");
        clear_in(); issue_valid = 1; set_src(5'd0, 5'd9);
        cycle("load_use_stall");
        cycle("load_use_fwd_m");
        clear_in(); cycle("idle0");

        // Zero register and youngest-first priority
        write(5'd0, 2'd0);           cycle("wr_r0");
        write(5'd5, 2'd0);           cycle("wr_r5_a");
        write(5'd5, 2'd0);           cycle("wr_r5_b");
        clear_in(); issue_valid = 1; set_src(5'd0, 5'd5);
        cycle("prio_r0_r5");
        clear_in(); cycle("idle1"); cycle("idle2"); cycle("idle3");

        // Freeze, then flush
        write(5'd9, 2'd1);           cycle("load_issue2");
        clear_in(); issue_valid = 1; set_src(5'd9, 5'd0);
        stall_ext = 1;
        cycle("freeze1"); cycle("freeze2"); cycle("freeze3");
        stall_ext = 0; flush = 1;   cycle("flush");
        flush = 0;                  cycle("after_flush");
        clear_in();

        // MDU start followed by reads of HI/LO
        clear_in(); issue_valid = 1; issue_mdu_start = 1; cycle("mdu_start");
        clear_in(); issue_valid = 1; issue_mdu_read = 1;
        for (int i = 0; i < 6; i++) cycle("mdu_read");
        clear_in(); cycle("idle4");

        // Asynchronous reset with all entries valid and the MDU running
        clear_in(); issue_valid = 1; issue_mdu_start = 1; cycle("mdu_start2");
        write(5'd1, 2'd0); cycle("fill1");
        write(5'd2, 2'd0); cycle("fill2");
        write(5'd3, 2'd0); cycle("fill3");
        clear_in(); issue_valid = 1; issue_mdu_read = 1; set_src(5'd1, 5'd3);
        #2;
        resetn = 0;
        #1;
        check("async_rst_stall", 32'(stall_d), 32'd0);
        check("async_rst_fwd", 32'(fwd_sel), 32'd0);
        check("async_rst_busy", 32'(mdu_busy), 32'd0);
        model_reset();
        @(posedge clk); #1;
        resetn = 1;
        cycle("post_reset");
        clear_in();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            issue_valid     = ($urandom_range(0, 3) != 0);
            issue_we        = ($urandom_range(0, 3) != 0);
            issue_dst       = REG_W'($urandom_range(0, 7));
            issue_rdy       = 2'($urandom_range(0, 3));
            set_src(REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)));
            issue_mdu_start = ($urandom_range(0, 7) == 0);
            issue_mdu_read  = ($urandom_range(0, 7) == 0);
            stall_ext       = ($urandom_range(0, 9) == 0);
            flush           = ($urandom_range(0, 19) == 0);
            cycle("random");
        end
        clear_in();

        @(negedge clk); #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised decode-stage hazard unit; successor to the single-operand D-stage forwarding evaluator.
- Keeps its own shadow of producers in the E/M/W stages, with valid, destination and result-ready stage for each.
- For NUM_SRC source operands per cycle, resolves the forwarding select and raises a decode stall when the youngest producer's result is not yet available.
- Optionally tracks a multi-cycle multiply/divide unit (MDU) with a busy counter.

Parameters:
- NUM_SRC, 2, number of source operands evaluated per decode cycle.
- REG_W, 5, register index width; index 0 is hard-wired zero.
- MDU_LAT, 4, cycles the MDU is busy after an accepted start (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- issue_valid  in  1  a decode instruction is presented.
- issue_we  in  1  the instruction writes a register.
- issue_dst  in  REG_W  destination index.
- issue_rdy  in  2  stage at whose end the result becomes forwardable: 0=E (ALU), 1=M (load), 2=W; 3 is illegal and treated as 2.
- src_idx  in  NUM_SRC*REG_W  source indices, packed; port k at [k*REG_W +: REG_W].
- issue_mdu_start  in  1  instruction starts an MDU op.
- issue_mdu_read  in  1  instruction reads HI/LO.
- stall_ext  in  1  external pipeline freeze (memory wait).
- flush  in  1  kill all in-flight E/M/W producers.
- stall_d  out  1  decode must hold; the instruction is not accepted.
- fwd_sel  out  NUM_SRC*2  per-source select: 0=regfile, 1=E result, 2=M result, 3=W result.
- mdu_busy  out  1  MDU counter nonzero.

Behaviour:
- Shadow state: three entries E, M, W, each holding {v, dst, rdy}. Reset clears all v and the MDU counter. While in reset, stall_d=0, fwd_sel=0 and mdu_busy=0.
- Entry match for source k: entry.v & entry.dst==src_idx[k] & src_idx[k]!=0.
- Lookup priority is youngest first: E, then M, then W. Only the first match is considered.
- A match at stage position p (E=0, M=1, W=2) is available iff p >= entry.rdy.
  - Available: fwd_sel[k] = p+1.
  - Not available: hazard_k=1 and fwd_sel[k]=0.
- No match, or src_idx[k]==0: fwd_sel[k]=0, no hazard.
- stall_d = issue_valid & (OR of hazard_k | mdu_hazard). This output is combinational on the current state and inputs; it has no registered latency.
- Accept = issue_valid & ~stall_d & ~stall_ext.
- Shadow advance on each clock edge, first applicable rule wins:
  - flush: all v cleared. flush overrides stall_ext.
  - stall_ext: all entries hold.
  - Otherwise: W<-M, M<-E. E<-{issue_we & issue_dst!=0, issue_dst, issue_rdy} when accepted; otherwise E becomes a bubble (v=0).
- Same destination written twice in flight: the younger entry shadows the older one via the priority order.
- A match in W is always available; a W-stage hazard is impossible by construction.

Optional Feature:
- Macro HAZ_MDU_EN. With it defined:
  - The counter has width $clog2(MDU_LAT+1).
  - It loads MDU_LAT on an accepted issue_mdu_start.
  - Otherwise it decrements by 1 each cycle while nonzero, independent of stall_ext and flush; an in-flight MDU op cannot be aborted.
  - mdu_busy = counter!=0.
  - mdu_hazard = mdu_busy & (issue_mdu_start | issue_mdu_read).
- Without it: the MDU ports are ignored, there is no counter, and mdu_busy=0 and mdu_hazard=0.

Test Plan:
- Forwarding path per stage: ALU producer dst=8, rdy=0 accepted; next cycle src0=8 gives fwd_sel0=1, stall_d=0. One cycle later fwd_sel0=2; two cycles later fwd_sel0=3; three cycles later fwd_sel0=0.
- Load-use stall: load dst=9, rdy=1; next cycle src1=9 gives stall_d=1 and fwd_sel1=0. Following cycle (bubble inserted in E) gives fwd_sel1=2, stall_d=0.
- Zero register and priority: producers dst=0 and dst=5 in flight; src=0 gives fwd_sel 0, no stall. Back-to-back writes to 5 (E and M) with src=5 gives fwd_sel=1.
- Freeze and flush: with the load in E, stall_ext=1 for 3 cycles keeps stall_d=1 and the entry stays in E. A flush then clears it, and src=9 gives fwd_sel=0, stall_d=0.
- MDU busy (HAZ_MDU_EN defined, MDU_LAT=4): after an accepted start, mdu_busy=1 for 4 cycles. issue_mdu_read gives stall_d=1 in cycles 1-4 and is accepted in cycle 5. With the macro undefined, stall_d=0 throughout.
- Reset mid-operation: assert resetn=0 asynchronously with all entries valid; outputs go to 0 immediately, and after release src matches give fwd_sel=0.
